// File: rtl/mtimer_multi_pkg.sv
// Shared address map, control-register layout and reset constants for the
// memory-mapped machine timer.
package mtimer_multi_pkg;

   localparam logic [31:0] MTIMER_BASE_ADDR = 32'h0000_8000;

   localparam logic [31:0] OFF_CTRL       = 32'h00;
   localparam logic [31:0] OFF_MTIME_LO   = 32'h04;
   localparam logic [31:0] OFF_MTIME_HI   = 32'h08;
   localparam logic [31:0] OFF_CMP_LO0    = 32'h0C;
   localparam logic [31:0] OFF_CMP_STRIDE = 32'h08;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   // Channel-0 aliases of the legacy single-comparator map
   localparam logic [31:0] MTIME_LO_ADDR    = MTIMER_BASE_ADDR + OFF_MTIME_LO;
   localparam logic [31:0] MTIME_HI_ADDR    = MTIMER_BASE_ADDR + OFF_MTIME_HI;
   localparam logic [31:0] MTIMECMP_LO_ADDR = MTIMER_BASE_ADDR + OFF_CMP_LO0;
   localparam logic [31:0] MTIMECMP_HI_ADDR = MTIMER_BASE_ADDR + OFF_CMP_LO0 + 32'h4;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  presc;
      logic [6:0]  rsvd_lo;
      logic        en;
   } mtimer_ctrl_t;

   // First offset past the last comparator word for n channels
   function automatic logic [31:0] mtimer_map_end(input int n);
      return OFF_CMP_LO0 + 32'(n) * OFF_CMP_STRIDE;
   endfunction

endpackage

// File: rtl/mtimer_multi_if.sv
// Single-cycle request/response peripheral bus used by the machine timer.
interface mtimer_multi_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport slave  (input req_i, we_i, addr_i, wdata_i, output rvalid_o, rdata_o, err_o);
   modport master (output req_i, we_i, addr_i, wdata_i, input rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/mtimer_cmp_channel.sv
// One 64-bit mtimecmp register with its own word-write decode and a
// registered level-sensitive timer interrupt.
module mtimer_cmp_channel
   import mtimer_multi_pkg::*;
#(
   parameter int IDX = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] offset,
   input  logic [31:0] wdata,
   input  logic [63:0] mtime,
   output logic [63:0] cmp,
   output logic        mtip
);

   localparam logic [31:0] LO_OFF = OFF_CMP_LO0 + 32'(IDX) * OFF_CMP_STRIDE;
   localparam logic [31:0] HI_OFF = LO_OFF + 32'h4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp  <= MTIMECMP_RESET;
         mtip <= 1'b0;
      end else begin
         if (wr_en && offset == LO_OFF) cmp[31:0]  <= wdata;
         if (wr_en && offset == HI_OFF) cmp[63:32] <= wdata;
         mtip <= (mtime >= cmp);
      end
   end

endmodule

// File: rtl/mtimer_multi.sv
// Machine timer: prescaled 64-bit mtime, tear-free high-word snapshot and
// N_CHANNELS mtimecmp comparators behind a one-cycle peripheral bus.
module mtimer_multi
   import mtimer_multi_pkg::*;
#(
   parameter int          XLEN       = 32,
   parameter int          N_CHANNELS = 1,
   parameter logic [31:0] BASE_ADDR  = MTIMER_BASE_ADDR,
   parameter int          PRESC_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   mtimer_multi_if.slave         bus,
   output logic [63:0]           mtime_o,
   output logic [N_CHANNELS-1:0] mtip_o
);

   logic [63:0]      mtime;
   logic             en;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] pc;
   logic [31:0]      snap;
   logic             snap_valid;
   logic [63:0]      cmp_val [N_CHANNELS];
   logic [31:0]      offset;
   logic             addr_ok, wr, rd, tick;
   logic             wr_ctrl, wr_lo, wr_hi, rd_lo, rd_hi;
   logic [XLEN-1:0]  rd_data;
   mtimer_ctrl_t     ctrl_rd;

   assign offset  = bus.addr_i - BASE_ADDR;
   assign addr_ok = (bus.addr_i[1:0] == 2'b00) && (offset < mtimer_map_end(N_CHANNELS));
   assign wr      = bus.req_i && bus.we_i && addr_ok;
   assign rd      = bus.req_i && !bus.we_i && addr_ok;
   assign wr_ctrl = wr && offset == OFF_CTRL;
   assign wr_lo   = wr && offset == OFF_MTIME_LO;
   assign wr_hi   = wr && offset == OFF_MTIME_HI;
   assign rd_lo   = rd && offset == OFF_MTIME_LO;
   assign rd_hi   = rd && offset == OFF_MTIME_HI;
   assign tick    = en && (pc == presc);
   assign mtime_o = mtime;

   always_comb begin
      ctrl_rd       = '0;
      ctrl_rd.en    = en;
      ctrl_rd.presc = 8'(presc);
   end

   always_comb begin
      rd_data = '0;
      if (offset == OFF_CTRL)          rd_data = ctrl_rd;
      else if (offset == OFF_MTIME_LO) rd_data = mtime[31:0];
      else if (offset == OFF_MTIME_HI) rd_data = snap_valid ? snap : mtime[63:32];
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (offset == OFF_CMP_LO0 + 32'(i) * OFF_CMP_STRIDE)         rd_data = cmp_val[i][31:0];
         if (offset == OFF_CMP_LO0 + 32'(i) * OFF_CMP_STRIDE + 32'h4) rd_data = cmp_val[i][63:32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en           <= 1'b1;
         presc        <= '0;
         pc           <= '0;
         mtime        <= '0;
         snap         <= '0;
         snap_valid   <= 1'b0;
         bus.rvalid_o <= 1'b0;
         bus.rdata_o  <= '0;
         bus.err_o    <= 1'b0;
      end else begin
         bus.rvalid_o <= bus.req_i;
         bus.err_o    <= bus.req_i && !addr_ok;
         bus.rdata_o  <= rd ? rd_data : '0;

         if (wr_ctrl) begin
            en    <= bus.wdata_i[0];
            presc <= bus.wdata_i[8 +: PRESC_W];
         end

         if (wr_ctrl || wr_lo || wr_hi || tick) pc <= '0;
         else if (en)                           pc <= pc + 1'b1;

         // Software writes win over the increment; the other half is held
         if (wr_lo)      mtime[31:0]  <= bus.wdata_i;
         else if (wr_hi) mtime[63:32] <= bus.wdata_i;
         else if (tick)  mtime        <= mtime + 64'd1;

         if (wr_lo || wr_hi) snap_valid <= 1'b0;
         else if (rd_lo) begin
            snap       <= mtime[63:32];
            snap_valid <= 1'b1;
         end else if (rd_hi) snap_valid <= 1'b0;
      end
   end

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
      mtimer_cmp_channel #(.IDX(g)) u_ch (
         .clk    (clk),
         .rst    (rst),
         .wr_en  (wr),
         .offset (offset),
         .wdata  (bus.wdata_i),
         .mtime  (mtime),
         .cmp    (cmp_val[g]),
         .mtip   (mtip_o[g])
      );
   end

endmodule
